pim_serial_adder: RTL and testbench

//   Parametrised digit-serial adder/subtractor: a WIDTH-bit operation is

---
 rtl/pim_serial_adder.sv | 142 ++++++++++++++
 tb/tb_pim_serial_adder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pim_serial_adder.sv
// Digit-serial adder/subtractor for the PIM arithmetic datapath.
// A WIDTH-bit operation is processed DIGIT bits per cycle, LSB first, and the
// carry is held in a flop between digits. Subtraction is a + ~b + 1, so the
// incoming cin is a borrow when sub=1, and cout reads as "no borrow".
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | waiting for operands, in_ready=1
//  RUN   | one digit per cycle, counter k selects the digit
//  DONE  | result presented with out_valid=1 until out_ready
module pim_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    int               base;
    logic [DIGIT-1:0] a_dig, b_dig, dig_s;
    logic             dig_c;
    logic             c_msb_in;

    assign base  = int'(cnt_q) * DIGIT;
    assign a_dig = DIGIT'(a_q >> base);
    assign b_dig = DIGIT'(b_q >> base);

    // DIGIT-bit ripple add; also keeps the carry entering the top bit for overflow
    always_comb begin : ripple
        logic c;
        c        = carry_q;
        dig_s    = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb_in = c;
            dig_s[i] = a_dig[i] ^ b_dig[i] ^ c;
            c        = (a_dig[i] & b_dig[i]) | (a_dig[i] & c) | (b_dig[i] & c);
        end
        dig_c = c;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: DIGIT] = dig_s;
                carry_d              = dig_c;
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = dig_c;
                    ovf_d   = c_msb_in ^ dig_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pim_serial_adder.sv
// Bench for pim_serial_adder: directed vectors on the 8x2 instance plus
// random sweeps on 8x1, 8x8 and 16x4 instances sharing the operand bus.
module tb_pim_serial_adder;

    logic        clk;
    logic        rst_n;
    logic [15:0] a, b;
    logic        cin, sub;
    logic [3:0]  iv, ordy;
    logic [3:0]  ir, ov, co, of, bz;
    logic [7:0]  s0, s1, s2;
    logic [15:0] s3;
    int          total;
    int          bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pim_serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0),
        .cout(co[0]), .ovf(of[0]), .busy(bz[0]));

    pim_serial_adder #(.WIDTH(8), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1),
        .cout(co[1]), .ovf(of[1]), .busy(bz[1]));

    pim_serial_adder #(.WIDTH(8), .DIGIT(8)) dut_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2),
        .cout(co[2]), .ovf(of[2]), .busy(bz[2]));

    pim_serial_adder #(.WIDTH(16), .DIGIT(4)) dut_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov[3]), .out_ready(ordy[3]), .sum(s3),
        .cout(co[3]), .ovf(of[3]), .busy(bz[3]));

    logic [15:0] sum_m [4];
    assign sum_m[0] = {8'h00, s0};
    assign sum_m[1] = {8'h00, s1};
    assign sum_m[2] = {8'h00, s2};
    assign sum_m[3] = s3;

    // Present operands to instance s while it is idle, then count cycles to out_valid.
    // Entered and left at posedge+1.
    task automatic run_op(input int s, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic su, output int lat);
        a    = av;
        b    = bv;
        cin  = ci;
        sub  = su;
        ordy = '0;
        iv   = 4'b0001 << s;
        @(posedge clk); #1;
        iv  = '0;
        lat = 0;
        while (ov[s] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake(input int s);
        ordy[s] = 1'b1;
        @(posedge clk); #1;
        ordy = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        iv = '0; ordy = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", ir[0]); end
        total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", ov[0]); end
        total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bz[0]); end
        total++; if (s0 !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", s0); end
        total++; if ({co[0], of[0]} !== 2'b00) begin bad++; $display("FAIL reset_cout_ovf got=%b want=00", {co[0], of[0]}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        logic [7:0] va [5] = '{8'h5A, 8'hFF, 8'hFF, 8'h7F, 8'h00};
        logic [7:0] vb [5] = '{8'h3C, 8'h01, 8'h01, 8'h00, 8'h00};
        logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] es [5] = '{8'h96, 8'h00, 8'h01, 8'h80, 8'h00};
        logic       ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       eo [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(0, {8'h00, va[i]}, {8'h00, vb[i]}, vc[i], 1'b0, lat);
            total++; if (lat != 4) begin bad++; $display("FAIL add_latency[%0d] got=%0d want=4", i, lat); end
            total++; if (s0 !== es[i]) begin bad++; $display("FAIL add_sum[%0d] got=%h want=%h", i, s0, es[i]); end
            total++; if (co[0] !== ec[i]) begin bad++; $display("FAIL add_cout[%0d] got=%b want=%b", i, co[0], ec[i]); end
            total++; if (of[0] !== eo[i]) begin bad++; $display("FAIL add_ovf[%0d] got=%b want=%b", i, of[0], eo[i]); end
            handshake(0);
            total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL add_ready_after[%0d] got=%b want=1", i, ir[0]); end
        end
    endtask

    task automatic test_sub;
        logic [7:0] va [4] = '{8'h10, 8'h80, 8'h00, 8'h05};
        logic [7:0] vb [4] = '{8'h20, 8'h01, 8'h00, 8'h05};
        logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] es [4] = '{8'hF0, 8'h7F, 8'hFF, 8'h00};
        logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       eo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(0, {8'h00, va[i]}, {8'h00, vb[i]}, vc[i], 1'b1, lat);
            total++; if (lat != 4) begin bad++; $display("FAIL sub_latency[%0d] got=%0d want=4", i, lat); end
            total++; if (s0 !== es[i]) begin bad++; $display("FAIL sub_sum[%0d] got=%h want=%h", i, s0, es[i]); end
            total++; if (co[0] !== ec[i]) begin bad++; $display("FAIL sub_cout[%0d] got=%b want=%b", i, co[0], ec[i]); end
            total++; if (of[0] !== eo[i]) begin bad++; $display("FAIL sub_ovf[%0d] got=%b want=%b", i, of[0], eo[i]); end
            handshake(0);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        run_op(0, 16'h005A, 16'h003C, 1'b0, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1;
            a     = 16'($urandom);
            b     = 16'($urandom);
            sub   = i[0];
            cin   = i[1];
            @(posedge clk); #1;
            total++; if (ov[0] !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d] got=%b want=1", i, ov[0]); end
            total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, ir[0]); end
            total++; if ({s0, co[0], of[0]} !== {8'h96, 1'b0, 1'b1})
                begin bad++; $display("FAIL bp_result[%0d] got=%h/%b/%b want=96/0/1", i, s0, co[0], of[0]); end
        end
        iv = '0;
        handshake(0);
        total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", ov[0]); end
        total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", ir[0]); end
        total++; if (s0 !== 8'h96) begin bad++; $display("FAIL bp_sum_kept got=%h want=96", s0); end
        @(posedge clk); #1;
        total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL bp_no_extra_op got=%b want=0", bz[0]); end
    endtask

    task automatic test_reset_mid;
        int lat;
        a = 16'h0033; b = 16'h0044; cin = 1'b0; sub = 1'b0; ordy = '0;
        iv = 4'b0001;
        @(posedge clk); #1;
        iv = '0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", ir[0]); end
        total++; if ({ov[0], bz[0]} !== 2'b00) begin bad++; $display("FAIL rmid_valid_busy got=%b want=00", {ov[0], bz[0]}); end
        total++; if ({s0, co[0], of[0]} !== 10'h000)
            begin bad++; $display("FAIL rmid_result got=%h/%b/%b want=00/0/0", s0, co[0], of[0]); end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL rmid_no_valid got=%b want=0", ov[0]); end
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        total++; if (lat != 4) begin bad++; $display("FAIL rmid_next_latency got=%0d want=4", lat); end
        total++; if (s0 !== 8'h02) begin bad++; $display("FAIL rmid_next_sum got=%h want=02", s0); end
        handshake(0);
    endtask

    task automatic test_sweep(input int s);
        int      w, n, lat;
        longint  mask, av, bv, ci, su, sa, sb, r, lo, hi;
        longint  es, ec, eo;
        w    = (s == 3) ? 16 : 8;
        n    = (s == 1) ? 8 : (s == 2) ? 1 : 4;
        mask = (64'd1 << w) - 1;
        lo   = -(64'd1 << (w - 1));
        hi   = (64'd1 << (w - 1)) - 1;
        for (int i = 0; i < 1000; i++) begin
            av = longint'($urandom) & mask;
            bv = longint'($urandom) & mask;
            ci = longint'($urandom_range(0, 1));
            su = longint'($urandom_range(0, 1));
            sa = av[w-1] ? av - (mask + 1) : av;
            sb = bv[w-1] ? bv - (mask + 1) : bv;
            if (su == 0) begin
                es = (av + bv + ci) & mask;
                ec = ((av + bv + ci) > mask) ? 1 : 0;
                r  = sa + sb + ci;
            end else begin
                es = (av - bv - ci) & mask;
                ec = (av >= bv + ci) ? 1 : 0;
                r  = sa - sb - ci;
            end
            eo = (r > hi || r < lo) ? 1 : 0;
            run_op(s, av[15:0], bv[15:0], ci[0], su[0], lat);
            total++; if (lat != n) begin bad++; $display("FAIL sweep%0d_latency[%0d] got=%0d want=%0d", s, i, lat, n); end
            total++; if (sum_m[s] !== es[15:0]) begin bad++; $display("FAIL sweep%0d_sum[%0d] got=%h want=%h", s, i, sum_m[s], es[15:0]); end
            total++; if (co[s] !== ec[0]) begin bad++; $display("FAIL sweep%0d_cout[%0d] got=%b want=%b", s, i, co[s], ec[0]); end
            total++; if (of[s] !== eo[0]) begin bad++; $display("FAIL sweep%0d_ovf[%0d] got=%b want=%b", s, i, of[s], eo[0]); end
            handshake(s);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_sweep(1);
        test_sweep(2);
        test_sweep(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
